// File: rtl/wb_single_master.sv
// Wishbone classic initiator: one command in, one single (non-burst) bus cycle out, one response pulse back.
// Optional abort-on-timeout is built when WB_MASTER_TIMEOUT_EN is defined.
module wb_single_master #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_adr_i,
  input  logic [15:0]       cmd_dat_i,
  input  logic [1:0]        cmd_sel_i,
  output logic              rsp_valid_o,
  output logic [15:0]       rsp_dat_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [15:0]       wb_dat_o,
  input  logic [15:0]       wb_dat_i,
  output logic [1:0]        wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic              wb_ack_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t state_q, state_d;
  logic   timeout_hit;
  logic   accept;

  assign cmd_ready_o = (state_q == IDLE);
  assign accept      = (state_q == IDLE) && cmd_valid_i;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt_q;

  // Counter sits at zero outside BUS, so every transfer starts from a clean count.
  always_ff @(posedge clk_i) begin
    if (rst_i)                            to_cnt_q <= '0;
    else if (state_q != BUS)              to_cnt_q <= '0;
    else if (!wb_ack_i)                   to_cnt_q <= to_cnt_q + 1'b1;
  end

  // Ack has priority over an expiring count in the same cycle.
  assign timeout_hit = (state_q == BUS) && !wb_ack_i && (to_cnt_q == CNT_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES < 1);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid_i) state_d = BUS;
      BUS:     if (wb_ack_i || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered bus and response outputs; stale acks outside BUS fall through untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      if (accept) begin
        wb_adr_o <= cmd_adr_i;
        wb_dat_o <= cmd_dat_i;
        wb_sel_o <= cmd_sel_i;
        wb_we_o  <= cmd_we_i;
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
      end else if (state_q == BUS) begin
        if (wb_ack_i) begin
          wb_cyc_o    <= 1'b0;
          wb_stb_o    <= 1'b0;
          wb_we_o     <= 1'b0;
          rsp_valid_o <= 1'b1;
          rsp_dat_o   <= wb_we_o ? 16'h0000 : wb_dat_i;
          rsp_err_o   <= 1'b0;
        end else if (timeout_hit) begin
          wb_cyc_o    <= 1'b0;
          wb_stb_o    <= 1'b0;
          wb_we_o     <= 1'b0;
          rsp_valid_o <= 1'b1;
          rsp_dat_o   <= 16'h0000;
          rsp_err_o   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_single_master.sv
// Directed bench for wb_single_master with a scoreboard of expected responses and a
// configurable registered-ack responder (wait states, lingering ack, never-ack).
module tb_wb_single_master;

  localparam int ADDR_W = 8;
  localparam int TO     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_we = 1'b0;
  logic [ADDR_W-1:0] cmd_adr = '0;
  logic [15:0]       cmd_dat = '0;
  logic [1:0]        cmd_sel = '0;
  logic              rsp_valid;
  logic [15:0]       rsp_dat;
  logic              rsp_err;
  logic [ADDR_W-1:0] wb_adr;
  logic [15:0]       wb_dat_o;
  logic [15:0]       wb_dat_i;
  logic [1:0]        wb_sel;
  logic              wb_we, wb_cyc, wb_stb;
  logic              wb_ack = 1'b0;

  wb_single_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel),
    .wb_we_o(wb_we), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_ack_i(wb_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Responder: registered ack raised once `ack_at` cycles of stb have elapsed.
  logic [15:0] mem [256];
  int  ack_at = 1;
  bit  linger = 1'b0;
  bit  never  = 1'b0;
  int  wcnt   = 0;

  assign wb_dat_i = mem[wb_adr];

  always @(posedge clk) begin
    if (wb_cyc && wb_stb && !never) begin
      wcnt = wcnt + 1;
      if (wb_ack && wb_we) begin
        if (wb_sel[0]) mem[wb_adr][7:0]  <= wb_dat_o[7:0];
        if (wb_sel[1]) mem[wb_adr][15:8] <= wb_dat_o[15:8];
      end
      wb_ack <= linger ? (wcnt >= ack_at) : ((wcnt >= ack_at) && !wb_ack);
    end else begin
      wcnt = 0;
      wb_ack <= 1'b0;
    end
  end

  // Scoreboard entry: {err, dat}
  logic [16:0] exp_q [$];

  int rsp_cnt = 0, bus_cycles = 0, cyc_len = 0, last_cyc_len = 0, gap = 0, last_gap = 99;
  logic prev_rsp = 1'b0;
  logic [ADDR_W-1:0] prev_adr = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (wb_cyc) begin
        if (cyc_len > 0) chk("adr_stable", 32'(wb_adr), 32'(prev_adr));
        if (cyc_len == 0 && bus_cycles > 0) last_gap = gap;
        cyc_len++;
        gap = 0;
      end else begin
        if (cyc_len > 0) begin
          last_cyc_len = cyc_len;
          bus_cycles++;
        end
        cyc_len = 0;
        gap++;
      end
      prev_adr = wb_adr;
      if (rsp_valid) begin
        logic [16:0] e;
        rsp_cnt++;
        chk("rsp_single_cycle", 32'(prev_rsp), 32'd0);
        if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_dat", 32'(rsp_dat), 32'(e[15:0]));
          chk("rsp_err", 32'(rsp_err), 32'(e[16]));
        end
      end
      prev_rsp = rsp_valid;
    end else begin
      prev_rsp = 1'b0;
    end
  end

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 100 && rsp_cnt < target; i++) @(negedge clk);
    chk("rsp_arrived", 32'(rsp_cnt >= target), 32'd1);
  endtask

  task automatic issue(input logic we, input logic [ADDR_W-1:0] adr,
                       input logic [15:0] dat, input logic [1:0] sel);
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int base, bc;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_cyc", 32'(wb_cyc), 32'd0);
    chk("rst_stb", 32'(wb_stb), 32'd0);
    chk("rst_we", 32'(wb_we), 32'd0);
    chk("rst_adr", 32'(wb_adr), 32'd0);
    chk("rst_dat", 32'(wb_dat_o), 32'd0);
    chk("rst_sel", 32'(wb_sel), 32'd0);
    chk("rst_rsp", {15'd0, rsp_valid, rsp_dat}, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);

    // Single write, 1-cycle-ack responder
    ack_at = 1; linger = 1'b0;
    exp_q.push_back({1'b0, 16'h0000});
    base = rsp_cnt;
    issue(1'b1, 8'h10, 16'hBEEF, 2'b11);
    chk("wr_cyc", 32'({wb_cyc, wb_stb, wb_we}), 32'b111);
    chk("wr_adr", 32'(wb_adr), 32'h10);
    chk("wr_dat", 32'(wb_dat_o), 32'hBEEF);
    chk("wr_sel", 32'(wb_sel), 32'h3);
    chk("wr_busy", 32'(cmd_ready), 32'd0);
    wait_rsp(base + 1);
    repeat (3) @(negedge clk);
    chk("wr_mem", 32'(mem[8'h10]), 32'hBEEF);
    chk("wr_rsp_count", 32'(rsp_cnt - base), 32'd1);

    // Read with 3 wait states
    ack_at = 3; mem[8'h20] = 16'h1234;
    exp_q.push_back({1'b0, 16'h1234});
    base = rsp_cnt;
    issue(1'b0, 8'h20, 16'h0000, 2'b11);
    chk("rd_we", 32'({wb_cyc, wb_we}), 32'b10);
    wait_rsp(base + 1);
    repeat (2) @(negedge clk);
    chk("rd_cyc_len", 32'(last_cyc_len), 32'd4);

    // Back-to-back writes with a lingering registered ack
    ack_at = 1; linger = 1'b1;
    exp_q.push_back({1'b0, 16'h0000});
    exp_q.push_back({1'b0, 16'h0000});
    base = rsp_cnt; bc = bus_cycles;
    cmd_we = 1'b1; cmd_adr = 8'h30; cmd_dat = 16'h0001; cmd_sel = 2'b11; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_adr = 8'h31; cmd_dat = 16'h0002;
    for (int i = 0; i < 50 && !(wb_cyc && wb_dat_o == 16'h0002); i++) @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_second_on_bus", 32'(wb_cyc && wb_dat_o == 16'h0002), 32'd1);
    wait_rsp(base + 2);
    repeat (6) @(negedge clk);
    chk("b2b_rsp_count", 32'(rsp_cnt - base), 32'd2);
    chk("b2b_bus_cycles", 32'(bus_cycles - bc), 32'd2);
    chk("b2b_gap_ge2", 32'(last_gap >= 2), 32'd1);
    chk("b2b_mem0", 32'(mem[8'h30]), 32'h0001);
    chk("b2b_mem1", 32'(mem[8'h31]), 32'h0002);
    linger = 1'b0;

    // Reset while waiting on a responder that never acks
    never = 1'b1;
    base = rsp_cnt;
    issue(1'b0, 8'h40, 16'h0000, 2'b01);
    repeat (2) @(negedge clk);
    chk("mid_in_bus", 32'(wb_cyc), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_cyc", 32'({wb_cyc, wb_stb}), 32'd0);
    chk("mid_rsp", 32'(rsp_valid), 32'd0);
    chk("mid_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_no_rsp", 32'(rsp_cnt - base), 32'd0);
    never = 1'b0;

`ifdef WB_MASTER_TIMEOUT_EN
    // Timeout: no ack ever
    never = 1'b1; mem[8'h50] = 16'hA5A5;
    exp_q.push_back({1'b1, 16'h0000});
    base = rsp_cnt;
    issue(1'b0, 8'h50, 16'h0000, 2'b11);
    wait_rsp(base + 1);
    repeat (2) @(negedge clk);
    chk("to_cyc_len", 32'(last_cyc_len), 32'(TO));
    never = 1'b0;

    // Ack arrives in the last BUS cycle before the timeout would fire
    ack_at = TO - 1; mem[8'h51] = 16'h5A5A;
    exp_q.push_back({1'b0, 16'h5A5A});
    base = rsp_cnt;
    issue(1'b0, 8'h51, 16'h0000, 2'b11);
    wait_rsp(base + 1);
    repeat (2) @(negedge clk);
    chk("tie_cyc_len", 32'(last_cyc_len), 32'(TO));
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
